// File: rtl/parking_pkg.sv
// parking_pkg: sensor codes, command kinds and emulator states shared by the parking blocks
package parking_pkg;
  localparam logic [1:0] X_NONE = 2'b00;
  localparam logic [1:0] X_OUT  = 2'b01;
  localparam logic [1:0] X_IN   = 2'b10;
  localparam logic [1:0] X_BOTH = 2'b11;
  typedef enum logic [1:0] {K_ENTER, K_EXIT, K_BALK_ENTER, K_BALK_EXIT} cmd_kind_t;
  typedef enum logic [2:0] {S_IDLE, S_PH1, S_PH2, S_PH3, S_GAP} emu_state_t;
  function automatic logic [1:0] sensor_code(emu_state_t s, cmd_kind_t k);
    return s == S_PH2 ? X_BOTH
         : s == S_PH1 ? (k inside {K_ENTER, K_BALK_ENTER} ? X_IN : X_OUT)
         : s == S_PH3 ? (k inside {K_EXIT, K_BALK_ENTER} ? X_IN : X_OUT)
         : X_NONE;
  endfunction
endpackage

// File: rtl/parking_sensor_emulator_if.sv
// parking_sensor_emulator_if: command handshake (cmd_valid/cmd_ready, cmd_kind, hold_len)
interface parking_sensor_emulator_if import parking_pkg::*; #(parameter int HOLD_W = 8);
  logic              cmd_valid;
  logic              cmd_ready;
  cmd_kind_t         cmd_kind;
  logic [HOLD_W-1:0] hold_len;
  modport master(output cmd_valid, cmd_kind, hold_len, input cmd_ready);
  modport slave(input cmd_valid, cmd_kind, hold_len, output cmd_ready);
endinterface

// File: rtl/parking_phase_timer.sv
// parking_phase_timer: loadable down-counter; ports clk, reset_n, load/load_val in, expire out (last cycle of a loaded span)
module parking_phase_timer #(parameter int W = 8) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (!reset_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - W'(1);
  end
  assign expire = cnt == W'(1);
endmodule

// File: rtl/parking_sensor_emulator.sv
// parking_sensor_emulator: turns handshaked car-movement commands into sequenced gate-sensor codes
// ports: clk, reset_n (sync, active-low), cmd (slave handshake), x sensor code, busy, done pulse, enter/exit counters
module parking_sensor_emulator import parking_pkg::*; #(
  parameter int HOLD_W     = 8,
  parameter int GAP_CYCLES = 2,
  parameter int CNT_W      = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  parking_sensor_emulator_if.slave  cmd,
  output logic [1:0]                x,
  output logic                      busy,
  output logic                      done,
  output logic [CNT_W-1:0]          enter_cnt,
  output logic [CNT_W-1:0]          exit_cnt
);
  emu_state_t        state, state_d;
  cmd_kind_t         kind, kind_d;
  logic [HOLD_W-1:0] len, len_d, load_val;
  logic              hs, load, expire, finish;
  assign cmd.cmd_ready = state == S_IDLE;
  assign busy = state != S_IDLE;
  assign hs = cmd.cmd_valid && cmd.cmd_ready;
  assign finish = state == S_PH3 && expire;
  always_comb begin
    kind_d = hs ? cmd.cmd_kind : kind;
    len_d = hs ? (cmd.hold_len == '0 ? HOLD_W'(1) : cmd.hold_len) : len;
    load = hs || (expire && state inside {S_PH1, S_PH2, S_PH3});
    load_val = state == S_PH3 ? HOLD_W'(GAP_CYCLES) : len_d;
    unique case (state)
      S_IDLE:  state_d = hs ? S_PH1 : S_IDLE;
      S_PH1:   state_d = expire ? S_PH2 : S_PH1;
      S_PH2:   state_d = expire ? S_PH3 : S_PH2;
      S_PH3:   state_d = expire ? S_GAP : S_PH3;
      S_GAP:   state_d = expire ? S_IDLE : S_GAP;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      kind      <= K_ENTER;
      len       <= '0;
      x         <= X_NONE;
      done      <= 1'b0;
      enter_cnt <= '0;
      exit_cnt  <= '0;
    end else begin
      state     <= state_d;
      kind      <= kind_d;
      len       <= len_d;
      x         <= sensor_code(state_d, kind_d);
      done      <= finish;
      enter_cnt <= enter_cnt + CNT_W'(finish && kind == K_ENTER);
      exit_cnt  <= exit_cnt + CNT_W'(finish && kind == K_EXIT);
    end
  end
  parking_phase_timer #(.W(HOLD_W)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (load),
    .load_val (load_val),
    .expire   (expire)
  );
endmodule

// File: tb/tb_parking_sensor_emulator.sv
// tb_parking_sensor_emulator: directed and random commands checked against a sequence-level model
module tb_parking_sensor_emulator;
  import parking_pkg::*;
  localparam int GAP = 2;
  typedef struct {logic [1:0] x; bit done; logic [1:0] kind;} ent_t;
  logic clk, reset_n, reset_n_w;
  logic [1:0] x, x_w;
  logic busy, done, busy_w, done_w;
  logic [15:0] enter_cnt, exit_cnt;
  logic [1:0] enter_cnt_w, exit_cnt_w;
  parking_sensor_emulator_if #(.HOLD_W(8)) bus ();
  parking_sensor_emulator_if #(.HOLD_W(8)) bus_w ();
  parking_sensor_emulator #(.HOLD_W(8), .GAP_CYCLES(GAP), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .cmd(bus), .x(x), .busy(busy), .done(done),
    .enter_cnt(enter_cnt), .exit_cnt(exit_cnt)
  );
  parking_sensor_emulator #(.HOLD_W(8), .GAP_CYCLES(GAP), .CNT_W(2)) dut_w (
    .clk(clk), .reset_n(reset_n_w), .cmd(bus_w), .x(x_w), .busy(busy_w), .done(done_w),
    .enter_cnt(enter_cnt_w), .exit_cnt(exit_cnt_w)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  logic [1:0] p1_tbl [4] = '{2'b10, 2'b01, 2'b10, 2'b01};
  logic [1:0] p3_tbl [4] = '{2'b01, 2'b10, 2'b10, 2'b01};
  ent_t q[$];
  ent_t cur;
  bit busy_m;
  logic [15:0] m_enter, m_exit;
  int total, bad, hs_cnt;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic timeout(string tag);
    total++;
    bad++;
    $error("FAIL %s timeout waiting for sequence", tag);
  endtask
  task automatic step();
    int l;
    logic [1:0] k;
    @(posedge clk);
    if (!reset_n) begin
      q.delete();
      busy_m = 0;
      m_enter = '0;
      m_exit = '0;
      cur = '{x: 2'b00, done: 1'b0, kind: 2'b00};
    end else begin
      if (bus.cmd_valid && !busy_m) begin
        k = bus.cmd_kind;
        l = bus.hold_len == 0 ? 1 : int'(bus.hold_len);
        hs_cnt++;
        for (int i = 0; i < l; i++) q.push_back('{x: p1_tbl[k], done: 1'b0, kind: k});
        for (int i = 0; i < l; i++) q.push_back('{x: 2'b11, done: 1'b0, kind: k});
        for (int i = 0; i < l; i++) q.push_back('{x: p3_tbl[k], done: 1'b0, kind: k});
        for (int i = 0; i < GAP; i++) q.push_back('{x: 2'b00, done: i == 0, kind: k});
      end
      if (q.size() > 0) begin
        cur = q.pop_front();
        busy_m = 1;
        if (cur.done && cur.kind == 2'd0) m_enter++;
        if (cur.done && cur.kind == 2'd1) m_exit++;
      end else begin
        cur = '{x: 2'b00, done: 1'b0, kind: 2'b00};
        busy_m = 0;
      end
    end
    #1;
    chk("x", 32'(x), 32'(cur.x));
    chk("done", 32'(done), 32'(cur.done));
    chk("busy", 32'(busy), 32'(busy_m));
    chk("cmd_ready", 32'(bus.cmd_ready), 32'(!busy_m));
    chk("enter_cnt", 32'(enter_cnt), 32'(m_enter));
    chk("exit_cnt", 32'(exit_cnt), 32'(m_exit));
  endtask
  task automatic wait_idle(string tag);
    int g = 0;
    while (busy_m && g < 3000) begin
      step();
      g++;
    end
    if (busy_m) timeout(tag);
  endtask
  task automatic send(cmd_kind_t k, logic [7:0] h, string tag);
    int g = 0;
    bus.cmd_kind = k;
    bus.hold_len = h;
    bus.cmd_valid = 1'b1;
    step();
    while (!busy_m && g < 50) begin
      step();
      g++;
    end
    bus.cmd_valid = 1'b0;
    if (!busy_m) timeout(tag);
    wait_idle(tag);
  endtask
  initial begin
    int g;
    total = 0;
    bad = 0;
    hs_cnt = 0;
    busy_m = 0;
    m_enter = '0;
    m_exit = '0;
    reset_n = 1'b0;
    reset_n_w = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_kind = K_ENTER;
    bus.hold_len = 8'd3;
    bus_w.cmd_valid = 1'b0;
    bus_w.cmd_kind = K_ENTER;
    bus_w.hold_len = 8'd1;
    step();
    step();
    reset_n = 1'b1;
    step();
    step();
    send(K_ENTER, 8'd3, "enter");
    send(K_EXIT, 8'd0, "exit_zero_hold");
    send(K_BALK_ENTER, 8'd2, "balk_enter");
    send(K_BALK_EXIT, 8'd2, "balk_exit");
    bus.cmd_kind = K_ENTER;
    bus.hold_len = 8'd1;
    bus.cmd_valid = 1'b1;
    hs_cnt = 0;
    g = 0;
    while (hs_cnt < 4 && g < 200) begin
      step();
      g++;
    end
    bus.cmd_valid = 1'b0;
    if (hs_cnt < 4) timeout("back_to_back");
    wait_idle("back_to_back");
    bus.cmd_kind = K_ENTER;
    bus.hold_len = 8'd3;
    bus.cmd_valid = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    repeat (4) step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    step();
    for (int i = 0; i < 700; i++) begin
      bus.cmd_valid = $urandom_range(0, 3) == 0;
      bus.cmd_kind = cmd_kind_t'($urandom_range(0, 3));
      bus.hold_len = 8'($urandom_range(0, 5));
      reset_n = $urandom_range(0, 199) != 0;
      step();
    end
    reset_n = 1'b1;
    bus.cmd_valid = 1'b0;
    step();
    wait_idle("random");
    reset_n_w = 1'b1;
    bus_w.cmd_valid = 1'b1;
    repeat (25) step();
    bus_w.cmd_valid = 1'b0;
    repeat (8) step();
    chk("wrap_enter_cnt", 32'(enter_cnt_w), 32'd1);
    chk("wrap_exit_cnt", 32'(exit_cnt_w), 32'd0);
    chk("wrap_x_idle", 32'(x_w), 32'd0);
    chk("wrap_ready", 32'(bus_w.cmd_ready), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
